// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receive path: frame states, frame/packet sizes,
// and bit positions within the mouse status byte.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_PKT_BYTES = 3;

    localparam int PS2_L_BIT     = 0;
    localparam int PS2_R_BIT     = 1;
    localparam int PS2_M_BIT     = 2;
    localparam int PS2_SYNC_BIT  = 3;
    localparam int PS2_XSIGN_BIT = 4;
    localparam int PS2_YSIGN_BIT = 5;
    localparam int PS2_XOVF_BIT  = 6;
    localparam int PS2_YOVF_BIT  = 7;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: data-line synchronizer, start/data/parity/stop FSM and mid-frame watchdog.
// Parity checking is compiled in only when PS2_RX_PARITY_CHK_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fall_edge,
    input  logic       ps2_d_mouse,
    input  logic       rx_en,
    output logic [7:0] byte_data,
    output logic       byte_stb,
    output logic       err_stb,
    output logic       frame_busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(PS2_DATA_BITS);

    logic          d_meta;
    logic          d_s;
    frame_state_t  state;
    frame_state_t  state_nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] wd;
    logic          timeout;
    logic          par_err;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_meta <= 1'b1;
            d_s    <= 1'b1;
        end else begin
            d_meta <= ps2_d_mouse;
            d_s    <= d_meta;
        end
    end

    // Fires on the cycle the count would reach TIMEOUT_CYC; a coincident edge wins.
    assign timeout = (state != IDLE) && !fall_edge && (wd == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before any branch so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (!rx_en || timeout) begin
            state_nxt = IDLE;
        end else if (fall_edge) begin
            unique case (state)
                IDLE:    if (!d_s) state_nxt = DATA;
                DATA:    if (cnt == CW'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_stb   = 1'b0;
        err_stb    = 1'b0;
        frame_busy = (state != IDLE);
        if (rx_en) begin
            if (timeout) begin
                err_stb = 1'b1;
            end else if (fall_edge && state == STOP) begin
                if (d_s && !par_err) byte_stb = 1'b1;
                else                 err_stb  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            byte_data <= '0;
            wd        <= '0;
        end else begin
            if (!rx_en || fall_edge || timeout || state == IDLE) wd <= '0;
            else                                                  wd <= wd + 1'b1;

            if (rx_en && fall_edge) begin
                if (state == IDLE) begin
                    cnt <= '0;
                end else if (state == DATA) begin
                    byte_data[cnt] <= d_s;
                    cnt            <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef PS2_RX_PARITY_CHK_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         par_bit <= 1'b0;
        else if (rx_en && fall_edge && state == PARITY) par_bit <= d_s;
    end

    // Odd parity: data plus parity bit must XOR to 1.
    assign par_err = ~(^{byte_data, par_bit});
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/ps2_mouse_rx_ctrl.sv
// PS/2 mouse receive controller: groups received bytes into 3-byte packets with sign-extended deltas.
// Optional parity checking in the frame receiver is enabled by PS2_RX_PARITY_CHK_EN.
module ps2_mouse_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fall_edge,
    input  logic       ps2_d_mouse,
    input  logic       rx_en,
    output logic       pkt_valid,
    output logic [7:0] pkt_status,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0] IDX_LAST = 2'(PS2_PKT_BYTES - 1);

    logic [7:0] byte_data;
    logic       byte_stb;
    logic       err_stb;
    logic       frame_busy;
    logic [1:0] idx;
    logic [7:0] hold0;
    logic [7:0] hold1;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk         (clk),
        .rst         (rst),
        .fall_edge   (fall_edge),
        .ps2_d_mouse (ps2_d_mouse),
        .rx_en       (rx_en),
        .byte_data   (byte_data),
        .byte_stb    (byte_stb),
        .err_stb     (err_stb),
        .frame_busy  (frame_busy)
    );

    assign busy = frame_busy || (idx != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= 2'd0;
            pkt_valid  <= 1'b0;
            frame_err  <= 1'b0;
            pkt_status <= 8'h00;
            pkt_dx     <= 9'h000;
            pkt_dy     <= 9'h000;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_en) begin
                idx <= 2'd0;
            end else if (err_stb) begin
                frame_err <= 1'b1;
                idx       <= 2'd0;
            end else if (byte_stb) begin
                if (idx == 2'd0) begin
                    // A first byte without the always-one bit means we joined mid-packet.
                    if (byte_data[PS2_SYNC_BIT]) idx <= 2'd1;
                end else if (idx == IDX_LAST) begin
                    pkt_status <= hold0;
                    pkt_dx     <= {hold0[PS2_XSIGN_BIT], hold1};
                    pkt_dy     <= {hold0[PS2_YSIGN_BIT], byte_data};
                    pkt_valid  <= 1'b1;
                    idx        <= 2'd0;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

    // NOTE: byte holding registers need no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (byte_stb) begin
            if (idx == 2'd0) hold0 <= byte_data;
            if (idx == 2'd1) hold1 <= byte_data;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx_ctrl.sv
// Self-checking bench for ps2_mouse_rx_ctrl: expected packets are queued as frames are driven
// and compared when pkt_valid pulses.
module tb_ps2_mouse_rx_ctrl;

    localparam int TO  = 100;
    localparam int GAP = 16;

    typedef struct packed {
        logic [7:0] status;
        logic [8:0] dx;
        logic [8:0] dy;
    } pkt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fall_edge = 1'b0;
    logic       ps2_d = 1'b1;
    logic       rx_en = 1'b1;
    logic       pkt_valid;
    logic [7:0] pkt_status;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic       frame_err;
    logic       busy;

    pkt_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pkt = 0;
    int   n_err = 0;
    int   exp_pkt = 0;
    int   exp_err = 0;
    int   cyc = 0;
    int   last_edge = 0;
    int   err_cyc = 0;

    ps2_mouse_rx_ctrl #(
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .fall_edge   (fall_edge),
        .ps2_d_mouse (ps2_d),
        .rx_en       (rx_en),
        .pkt_valid   (pkt_valid),
        .pkt_status  (pkt_status),
        .pkt_dx      (pkt_dx),
        .pkt_dy      (pkt_dy),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && pkt_valid) begin
            pkt_t e;
            n_pkt++;
            if (sb.size() == 0) begin
                check("sb_nonempty", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("pkt_status", pkt_status, e.status);
                check("pkt_dx", pkt_dx, e.dx);
                check("pkt_dy", pkt_dy, e.dy);
            end
        end
        if (rst && frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    // Entered and left just after a rising edge; the edge pulse lands gap cycles after entry.
    task automatic pulse_edge(input logic d, input int gap, input logic drop_en);
        ps2_d = d;
        repeat (gap - 1) @(posedge clk);
        #1 fall_edge = 1'b1;
        if (drop_en) rx_en = 1'b0;
        last_edge = cyc;
        @(posedge clk);
        #1 fall_edge = 1'b0;
        rx_en = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip = 1'b0, input int nbits = 11,
                              input int gap = GAP, input logic drop_stop = 1'b0);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) pulse_edge(f[i], gap, drop_stop && (i == 10));
        ps2_d = 1'b1;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int gap = GAP);
        pkt_t e;
        send_frame(b0, 1'b0, 11, gap);
        send_frame(b1, 1'b0, 11, gap);
        e.status = b0;
        e.dx     = {b0[4], b1};
        e.dy     = {b0[5], b2};
        if (b0[3]) begin
            sb.push_back(e);
            exp_pkt++;
        end
        send_frame(b2, 1'b0, 11, gap);
    endtask

    task automatic settle(input string tag);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_drained"}, sb.size(), 0);
        check({tag, "_errs"}, n_err, exp_err);
    endtask

    initial begin
        int e0;
        int p0;
        pkt_t e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_status", pkt_status, 8'h00);
        check("rst_dx", pkt_dx, 9'h000);
        check("rst_dy", pkt_dy, 9'h000);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send_packet(8'h28, 8'h05, 8'hFB);
        settle("basic");

        send_frame(8'h05);
        check("unsync_busy", busy, 0);
        send_packet(8'h09, 8'h10, 8'h20);
        settle("sync");

        send_frame(8'h28);
`ifdef PS2_RX_PARITY_CHK_EN
        send_frame(8'h05, 1'b1);
        exp_err++;
        check("par_busy", busy, 0);
`else
        e.status = 8'h28;
        e.dx     = 9'h005;
        e.dy     = 9'h102;
        sb.push_back(e);
        exp_pkt++;
        send_frame(8'h05, 1'b1);
`endif
        send_frame(8'h02);
        send_packet(8'h08, 8'h01, 8'h02);
        settle("parity");

        e0 = n_err;
        send_frame(8'hA5, 1'b0, 5);
        exp_err++;
        for (int i = 0; i < 3 * TO / 2 && n_err == e0; i++) @(posedge clk);
        #1;
        check("to_seen", n_err - e0, 1);
        check("to_delay", err_cyc - last_edge, TO + 1);
        check("to_busy", busy, 0);
        send_packet(8'h18, 8'h7F, 8'h80);
        settle("timeout");

        send_packet(8'h28, 8'h11, 8'h22, TO);
        settle("wd_edge");

        p0 = n_pkt;
        send_frame(8'h28);
        send_frame(8'h33, 1'b0, 5);
        rx_en = 1'b0;
        @(posedge clk);
        #1 rx_en = 1'b1;
        send_packet(8'h38, 8'h44, 8'h55);
        settle("rx_en");
        check("rx_en_one_pkt", n_pkt - p0, 1);

        p0 = n_pkt;
        send_frame(8'h28);
        send_frame(8'h01);
        send_frame(8'h02, 1'b0, 11, GAP, 1'b1);
        settle("commit_drop");
        check("commit_drop_nopkt", n_pkt - p0, 0);
        send_packet(8'h08, 8'h03, 8'h04);
        settle("after_drop");

        send_frame(8'h38);
        send_frame(8'h06);
        send_frame(8'h07, 1'b0, 6);
        rst = 1'b0;
        #1;
        check("arst_pkt_valid", pkt_valid, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_busy", busy, 0);
        check("arst_status", pkt_status, 8'h00);
        check("arst_dx", pkt_dx, 9'h000);
        check("arst_dy", pkt_dy, 9'h000);
        @(posedge clk);
        #1 rst = 1'b1;
        send_packet(8'h28, 8'h05, 8'hFB);
        settle("arst");

        check("pkt_total", n_pkt, exp_pkt);
        check("err_total", n_err, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_rx_ctrl.md
# ps2_mouse_rx_ctrl

Receive controller for the PS/2 mouse port: consumes the one-cycle `fall_edge` strobe produced by the PS/2 clock noise filter and sequences sampling of the mouse data line. It assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop) into bytes, then groups the bytes into 3-byte mouse packets. It delivers a validated packet with sign-extended X/Y deltas to the host logic, and watchdogs the line for stalled frames.

## Interface
- `TIMEOUT_CYC`, 50000: `clk` cycles without a `fall_edge` mid-frame before the frame is aborted (1 ms at 50 MHz).
- `TW`, `$clog2(TIMEOUT_CYC+1)`: width of the watchdog counter; derived, not overridden.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fall_edge`  in  1  one-cycle pulse, filtered PS/2 clock falling edge, synchronous to `clk`.
- `ps2_d_mouse`  in  1  raw PS/2 data line, asynchronous.
- `rx_en`  in  1  receive enable; low flushes any partial frame and packet.
- `pkt_valid`  out  1  one-cycle pulse; packet outputs valid this cycle and held until next packet.
- `pkt_status`  out  8  byte 0: {Yovf, Xovf, Ysign, Xsign, 1, M, R, L}.
- `pkt_dx`  out  9  signed X delta {Xsign, byte1}.
- `pkt_dy`  out  9  signed Y delta {Ysign, byte2}.
- `frame_err`  out  1  one-cycle pulse on parity error, bad stop bit, or timeout.
- `busy`  out  1  high while state is not IDLE or packet byte index is nonzero.

## Operation
- `ps2_d_mouse` passes through a 2-flop synchronizer (`d_s`); it is sampled only in cycles where `fall_edge`=1.
- Frame FSM: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall_edge` with `d_s`=0 (start bit), go to DATA with bit count 0. With `d_s`=1, remain in IDLE and raise no error.
  - DATA: each `fall_edge` shifts `d_s` into bit[cnt] of the shift register (LSB first). After the 8th bit, go to PARITY.
  - PARITY: capture `d_s`. Parity is good when the XOR of the 8 data bits and the parity bit equals 1. Go to STOP.
  - STOP: `d_s` must be 1. A good stop bit with good parity commits the byte. Any failure pulses `frame_err`, resets the byte index to 0, and discards the packet. Return to IDLE.
- Packet assembly: the byte index runs 0→1→2→0.
  - A byte committed at index 0 with bit3=0 is dropped as out of sync. The index stays 0 and no error is raised.
  - Committing index 2 loads `pkt_status`, `pkt_dx`, and `pkt_dy` and pulses `pkt_valid` in the same cycle.
- Watchdog: counts while state≠IDLE and clears on every `fall_edge`. When it reaches `TIMEOUT_CYC`: pulse `frame_err`, go to IDLE, reset the byte index to 0.
- `rx_en`=0: state goes to IDLE, byte index to 0, watchdog to 0. No error is raised. Packet outputs keep their last values.

## Timing
- Reset values: `pkt_valid`=0, `frame_err`=0, `busy`=0, `pkt_status`=8'h00, `pkt_dx`=9'h000, `pkt_dy`=9'h000, state IDLE, byte index 0.
- `pkt_valid` rises in the cycle after the `fall_edge` that samples the stop bit of byte 2 (registered output, 1-cycle latency).
- `frame_err` uses the same 1-cycle latency relative to the offending `fall_edge`. For a timeout, it rises 1 cycle after the count hits `TIMEOUT_CYC`.
- If `fall_edge` coincides with the watchdog terminal count, the edge wins: the watchdog clears and no timeout occurs.
- If `rx_en` falls in the same cycle as a committing `fall_edge`, `rx_en` wins: nothing is committed and there is no pulse.
- Async reset mid-frame clears everything immediately. The next frame must begin with a fresh start bit.

## Configuration
- `PS2_RX_PARITY_CHK_EN` defined: parity is checked as above, and a mismatch raises `frame_err`.
- Not defined: the parity bit is sampled and ignored. Only the stop bit and timeout can raise `frame_err`.

## Structure
- Shared package `ps2_pkg`:
  - frame-state enum (IDLE, DATA, PARITY, STOP);
  - constants `PS2_DATA_BITS`=8 and `PS2_PKT_BYTES`=3;
  - status-byte bit-position constants (L, R, M, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7).
- One sub-module, `ps2_frame_rx`, contains the synchronizer, frame FSM, watchdog, and parity logic. It outputs `byte_data[7:0]`, `byte_stb`, and `err_stb`.
- The top level holds the packet byte index, the sync check, and the output registers.

## Test plan
- Send packet 8'h28, 8'h05, 8'hFB at 50 µs bit period → one `pkt_valid`; `pkt_status`=8'h28, `pkt_dx`=9'h005, `pkt_dy`=9'h1FB (−5); `frame_err` never pulses.
- Send byte 8'h05 first (bit3=0), then 8'h09, 8'h10, 8'h20 → the first byte is dropped; `pkt_valid` with `pkt_status`=8'h09, `pkt_dx`=9'h010, `pkt_dy`=9'h020.
- Send byte 1 with flipped parity, with `PS2_RX_PARITY_CHK_EN` defined → `frame_err` pulse and byte index back to 0. With the macro undefined → the packet completes normally.
- Stop feeding `fall_edge` after the 4th data bit, with `TIMEOUT_CYC`=100 → `frame_err` 101 cycles after the last edge; `busy`=0; the next full packet is received correctly.
- Drop `rx_en` for 1 cycle mid byte 1, then send a full packet → no `frame_err`; exactly one `pkt_valid`, carrying the new packet.
- Assert `rst`=0 during byte 2 → all outputs reach their reset values within the same cycle; the following packet decodes correctly.
